// File: rtl/axis_byte2hex.sv
// AXI-Stream byte to ASCII-hex converter: two hex characters per byte, high nibble first,
// with CR LF at packet end and optionally every LINE_BYTES bytes within a packet.
module axis_byte2hex #(
  parameter int unsigned UPPERCASE  = 1,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int unsigned LC_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam bit          LINE_EN = (LINE_BYTES != 0);
  localparam logic [LC_W-1:0] LINE_LAST = LC_W'((LINE_BYTES > 0) ? LINE_BYTES - 1 : 0);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HI   = 3'd1;
  localparam logic [2:0] ST_LO   = 3'd2;
  localparam logic [2:0] ST_CR   = 3'd3;
  localparam logic [2:0] ST_LF   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [7:0]       byte_reg, byte_next;
  logic             last_reg, last_next;
  logic [LC_W-1:0]  line_cnt_reg, line_cnt_next;
  logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;

  logic       brk;
  logic       accept;
  logic [7:0] nib_char [2];

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'd0, n};
    end
    return ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'd0, n};
  endfunction

  // nib_char[1] is the high nibble (sent first), nib_char[0] the low nibble
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_nib
      assign nib_char[gi] = hex_char(byte_reg[gi*4 +: 4]);
    end
  endgenerate

  // A line break is due after this byte if it ends the packet or fills the line
  assign brk = last_reg || (LINE_EN && (line_cnt_reg == LINE_LAST));

  assign s_tready = rst_n && ((state_reg == ST_IDLE) ||
                              ((state_reg == ST_LO) && m_tready && !brk) ||
                              ((state_reg == ST_LF) && m_tready));
  assign accept   = s_tvalid && s_tready;

  assign m_tvalid = (state_reg != ST_IDLE);
  assign m_tlast  = (state_reg == ST_LF) && last_reg;
  assign pkt_cnt  = pkt_cnt_reg;

  always_comb begin
    m_tdata = 8'h00;
    case (state_reg)
      ST_HI:   m_tdata = nib_char[1];
      ST_LO:   m_tdata = nib_char[0];
      ST_CR:   m_tdata = 8'h0D;
      ST_LF:   m_tdata = 8'h0A;
      default: m_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    last_next     = last_reg;
    line_cnt_next = line_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;

    if (accept) begin
      byte_next = s_tdata;
      last_next = s_tlast;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_HI;
      end
      ST_HI: begin
        if (m_tready) state_next = ST_LO;
      end
      ST_LO: begin
        if (m_tready) begin
          if (brk) begin
            state_next    = ST_CR;
            line_cnt_next = '0;
          end else begin
            line_cnt_next = line_cnt_reg + LC_W'(1);
            state_next    = accept ? ST_HI : ST_IDLE;
          end
        end
      end
      ST_CR: begin
        if (m_tready) state_next = ST_LF;
      end
      ST_LF: begin
        if (m_tready) begin
          if (last_reg) begin
            line_cnt_next = '0;
            pkt_cnt_next  = pkt_cnt_reg + CNT_W'(1);
          end
          state_next = accept ? ST_HI : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      byte_reg     <= 8'h00;
      last_reg     <= 1'b0;
      line_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      last_reg     <= last_next;
      line_cnt_reg <= line_cnt_next;
      pkt_cnt_reg  <= pkt_cnt_next;
    end
  end

endmodule

// File: tb/tb_axis_byte2hex.sv
// Bench for axis_byte2hex: three configurations side by side, a vector table of
// expected character strings, a mid-packet reset sequence and randomized packets.
module tb_axis_byte2hex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_uc(input int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int p_lb(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 0);
  endfunction
  function automatic int p_cw(input int i);
    return (i == 2) ? 2 : 32;
  endfunction

  logic [2:0]       rst_n;
  logic [2:0][7:0]  s_tdata;
  logic [2:0]       s_tvalid, s_tlast, s_tready;
  logic [2:0][7:0]  m_tdata;
  logic [2:0]       m_tvalid, m_tlast, m_tready;
  logic [2:0][31:0] pkt_cnt_w;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      logic [p_cw(gi)-1:0] pc;
      axis_byte2hex #(
        .UPPERCASE (p_uc(gi)),
        .LINE_BYTES(p_lb(gi)),
        .CNT_W     (p_cw(gi))
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n[gi]),
        .s_tdata (s_tdata[gi]),
        .s_tvalid(s_tvalid[gi]),
        .s_tlast (s_tlast[gi]),
        .s_tready(s_tready[gi]),
        .m_tdata (m_tdata[gi]),
        .m_tvalid(m_tvalid[gi]),
        .m_tlast (m_tlast[gi]),
        .m_tready(m_tready[gi]),
        .pkt_cnt (pc)
      );
      assign pkt_cnt_w[gi] = 32'(pc);
    end
  endgenerate

  typedef struct {
    logic [7:0]  c;
    logic        l;
    int unsigned t;
  } chr_t;

  typedef struct {
    int    inst;
    string din;   // hex bytes, '/' ends a packet
    string dout;  // expected characters, '|' stands for CR LF
    int    pc;
  } vec_t;

  chr_t        got_q [3][$];
  chr_t        exp_q [3][$];
  int unsigned cyc = 0;
  int          rdy_mode [3] = '{1, 1, 1};  // 0 low, 1 high, 2 random
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    for (int i = 0; i < 3; i++) begin
      case (rdy_mode[i])
        0:       m_tready[i] = 1'b0;
        1:       m_tready[i] = 1'b1;
        default: m_tready[i] = 1'($urandom_range(0, 1));
      endcase
    end
    @(posedge clk);
    #1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Collects handshaken characters and checks AXI-S hold rules under stall
  logic [2:0]      stall_prev = '0;
  logic [2:0][7:0] stall_d;
  logic [2:0]      stall_l;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (stall_prev[i]) begin
        chk($sformatf("hold_valid%0d", i), 32'(m_tvalid[i]), 32'd1);
        chk($sformatf("hold_data%0d", i), 32'(m_tdata[i]), 32'(stall_d[i]));
        chk($sformatf("hold_last%0d", i), 32'(m_tlast[i]), 32'(stall_l[i]));
      end
      if (rst_n[i] && m_tvalid[i] && m_tready[i])
        got_q[i].push_back('{c: m_tdata[i], l: m_tlast[i], t: cyc});
      if (m_tvalid[i] && !m_tready[i])
        chk($sformatf("stall_s_tready%0d", i), 32'(s_tready[i]), 32'd0);
      stall_prev[i] <= rst_n[i] && m_tvalid[i] && !m_tready[i];
      stall_d[i]    <= m_tdata[i];
      stall_l[i]    <= m_tlast[i];
    end
  end

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= "a") return 4'(ch - 8'h57);
    if (ch >= "A") return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  // Reference: every byte gives two hex digits; CR LF after the packet's last byte,
  // or after every LINE_BYTES-th byte of the packet otherwise.
  function automatic void model_pkt(input int i, input logic [7:0] q[$]);
    string hs;
    int    lb;
    hs = (p_uc(i) != 0) ? "0123456789ABCDEF" : "0123456789abcdef";
    lb = p_lb(i);
    for (int k = 0; k < q.size(); k++) begin
      exp_q[i].push_back('{c: hs[q[k] / 16], l: 1'b0, t: 0});
      exp_q[i].push_back('{c: hs[q[k] % 16], l: 1'b0, t: 0});
      if (k == q.size() - 1) begin
        exp_q[i].push_back('{c: 8'h0D, l: 1'b0, t: 0});
        exp_q[i].push_back('{c: 8'h0A, l: 1'b1, t: 0});
      end else if (lb != 0 && ((k + 1) % lb) == 0) begin
        exp_q[i].push_back('{c: 8'h0D, l: 1'b0, t: 0});
        exp_q[i].push_back('{c: 8'h0A, l: 1'b0, t: 0});
      end
    end
  endfunction

  // Presents one byte (entered and left at a negedge) and waits for its acceptance
  task automatic send_byte(input int i, input logic [7:0] b, input logic l, output int unsigned acc);
    int t;
    s_tdata[i]  = b;
    s_tlast[i]  = l;
    s_tvalid[i] = 1'b1;
    t = 0;
    while (!s_tready[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
    acc = cyc;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int id);
    int          i;
    logic [7:0]  b[$];
    logic        l[$];
    logic [7:0]  e[$];
    int          np, p, t, mism, ntl;
    int unsigned acc, acc0;
    i = v.inst;
    p = 0;
    while (p < v.din.len()) begin
      if (v.din[p] == "/") begin
        l[l.size()-1] = 1'b1;
        p++;
      end else begin
        b.push_back({hexval(v.din[p]), hexval(v.din[p+1])});
        l.push_back(1'b0);
        p += 2;
      end
    end
    l[l.size()-1] = 1'b1;
    np = 0;
    foreach (l[k]) if (l[k]) np++;
    for (int k = 0; k < v.dout.len(); k++) begin
      if (v.dout[k] == "|") begin
        e.push_back(8'h0D);
        e.push_back(8'h0A);
      end else begin
        e.push_back(v.dout[k]);
      end
    end

    @(negedge clk);
    rdy_mode[i] = 1;
    @(negedge clk);
    got_q[i].delete();
    acc0 = 0;
    for (int k = 0; k < b.size(); k++) begin
      send_byte(i, b[k], l[k], acc);
      if (k == 0) acc0 = acc;
    end
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
    t = 0;
    while (got_q[i].size() < e.size() && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);

    chk($sformatf("vec%0d_nchars", id), 32'(got_q[i].size()), 32'(e.size()));
    mism = -1;
    ntl  = 0;
    for (int j = 0; j < got_q[i].size() && j < e.size(); j++) begin
      if (got_q[i][j].c !== e[j] && mism < 0) mism = j;
      if (got_q[i][j].l) ntl++;
    end
    checks++;
    if (mism >= 0) begin
      errors++;
      $display("FAIL vec%0d_chars: char %0d got %02h expected %02h", id, mism,
               got_q[i][mism].c, e[mism]);
    end
    chk($sformatf("vec%0d_tlast_count", id), 32'(ntl), 32'(np));
    if (got_q[i].size() > 0) begin
      chk($sformatf("vec%0d_final_tlast", id), 32'(got_q[i][got_q[i].size()-1].l), 32'd1);
      chk($sformatf("vec%0d_latency", id), got_q[i][0].t - acc0, 32'd1);
      chk($sformatf("vec%0d_no_bubbles", id),
          got_q[i][got_q[i].size()-1].t - got_q[i][0].t, 32'(e.size() - 1));
    end
    chk($sformatf("vec%0d_pkt_cnt", id), pkt_cnt_w[i], 32'(v.pc));
    $display("vec%0d inst%0d: %0d bytes in %0d packets -> %0d chars, pkt_cnt %0d",
             id, i, b.size(), np, got_q[i].size(), pkt_cnt_w[i]);
  endtask

  task automatic rand_run(input int i, input int npk);
    int          len, t, pk, badj, gl;
    bit          bad;
    logic [7:0]  q[$];
    logic [7:0]  gc;
    int unsigned acc;
    @(negedge clk);
    rdy_mode[i] = 2;
    got_q[i].delete();
    exp_q[i].delete();
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(1, 64);
      q.delete();
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      model_pkt(i, q);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_tvalid[i] = 1'b0;
          @(negedge clk);
        end
        send_byte(i, q[k], (k == len - 1), acc);
      end
      $display("rand inst%0d pkt %0d: %0d bytes", i, p, len);
    end
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
    t = 0;
    while (got_q[i].size() < exp_q[i].size() && t < 20000) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (4) @(negedge clk);
    chk($sformatf("rand%0d_nchars", i), 32'(got_q[i].size()), 32'(exp_q[i].size()));
    bad  = 1'b0;
    badj = -1;
    pk   = 0;
    for (int j = 0; j < exp_q[i].size(); j++) begin
      gc = (j < got_q[i].size()) ? got_q[i][j].c : 8'hFF;
      gl = (j < got_q[i].size()) ? int'(got_q[i][j].l) : -1;
      if (gc !== exp_q[i][j].c || gl != int'(exp_q[i][j].l)) begin
        if (!bad) badj = j;
        bad = 1'b1;
      end
      if (exp_q[i][j].l) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL rand%0d_pkt%0d: char %0d got %02h expected %02h", i, pk, badj,
                   (badj < got_q[i].size()) ? got_q[i][badj].c : 8'hFF, exp_q[i][badj].c);
        end
        bad = 1'b0;
        pk++;
      end
    end
    rdy_mode[i] = 1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs [7];
    vec_t        v;
    int unsigned acc;

    vecs[0] = '{0, "A5", "A5|", 1};
    vecs[1] = '{1, "3F", "3f|", 1};
    vecs[2] = '{1, "000102030405", "00010203|0405|", 2};
    vecs[3] = '{1, "00010203", "00010203|", 3};
    vecs[4] = '{2, "010203/040506", "010203|040506|", 2};
    vecs[5] = '{2, "07/08/09", "07|08|09|", 1};
    vecs[6] = '{0, "DEAD", "DEAD|", 2};

    rst_n    = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_m_tvalid%0d", i), 32'(m_tvalid[i]), 32'd0);
      chk($sformatf("reset_m_tdata%0d", i), 32'(m_tdata[i]), 32'd0);
      chk($sformatf("reset_m_tlast%0d", i), 32'(m_tlast[i]), 32'd0);
      chk($sformatf("reset_pkt_cnt%0d", i), pkt_cnt_w[i], 32'd0);
      chk($sformatf("reset_s_tready%0d", i), 32'(s_tready[i]), 32'd0);
    end
    rst_n = '1;
    @(negedge clk);

    for (int n = 0; n < 7; n++) apply_vec(vecs[n], n);

    // Reset while the low-nibble character of a byte is stalled on the output
    @(negedge clk);
    s_tdata[0]  = 8'h3C;
    s_tlast[0]  = 1'b0;
    s_tvalid[0] = 1'b1;
    chk("rst_seq_idle_s_tready", 32'(s_tready[0]), 32'd1);
    @(negedge clk);
    s_tvalid[0] = 1'b0;
    rdy_mode[0] = 0;
    chk("rst_seq_hi_char", 32'(m_tdata[0]), 32'h33);
    chk("rst_seq_hi_s_tready", 32'(s_tready[0]), 32'd0);
    @(negedge clk);
    chk("rst_seq_lo_char", 32'(m_tdata[0]), 32'h43);
    rst_n[0] = 1'b0;
    chk("rst_seq_s_tready_in_reset", 32'(s_tready[0]), 32'd0);
    @(negedge clk);
    chk("rst_seq_m_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("rst_seq_m_tdata", 32'(m_tdata[0]), 32'd0);
    chk("rst_seq_m_tlast", 32'(m_tlast[0]), 32'd0);
    chk("rst_seq_pkt_cnt", pkt_cnt_w[0], 32'd0);
    chk("rst_seq_s_tready", 32'(s_tready[0]), 32'd0);
    rst_n[0]    = 1'b1;
    rdy_mode[0] = 1;
    got_q[0].delete();
    repeat (4) @(negedge clk);
    chk("rst_seq_no_leftover_chars", 32'(got_q[0].size()), 32'd0);
    $display("rst_seq inst0: reset during LO, %0d chars after release", got_q[0].size());
    v = '{0, "12", "12|", 1};
    apply_vec(v, 7);

    rand_run(0, 100);
    rand_run(1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
